// File: rtl/drum_voice_player.sv
// Five-voice drum burst player: per-voice tone/burst generators, registered voice-count mixer
// and a 5-slot PWM DAC. Define HIT_LED_EN to add the stretched per-voice HitLed output.
module drum_voice_player #(
  parameter logic [15:0]        HALF_A    = 16'd227,
  parameter logic [15:0]        HALF_B    = 16'd303,
  parameter logic [15:0]        HALF_C    = 16'd382,
  parameter logic [15:0]        HALF_D    = 16'd455,
  parameter logic [15:0]        HALF_E    = 16'd607,
  parameter int                 BURST_W   = 20,
  parameter logic [BURST_W-1:0] BURST_LEN = 20'd500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CCEN,
  input  logic       Playing,
  input  logic       Ain,
  input  logic       Bin,
  input  logic       Cin,
  input  logic       Din,
  input  logic       Ein,
`ifdef HIT_LED_EN
  output logic [4:0] HitLed,
`endif
  output logic [4:0] VoiceActive,
  output logic [2:0] AudioSum,
  output logic       AudioPwm,
  output logic       Busy
);

  localparam logic [15:0] HALF [5] = '{HALF_A, HALF_B, HALF_C, HALF_D, HALF_E};

  logic [4:0]         w_hits;
  logic [4:0]         w_trig;
  logic [4:0]         w_levels;
  logic [4:0]         r_active;
  logic [4:0]         r_phase;
  logic [15:0]        r_tone_cnt  [5];
  logic [BURST_W-1:0] r_burst_cnt [5];
  logic [2:0]         r_sum;
  logic [2:0]         r_pwm_cnt;
  logic               r_pwm;

  assign w_hits   = {Ein, Din, Cin, Bin, Ain};
  assign w_trig   = {5{CCEN & Playing}} & w_hits;
  assign w_levels = r_active & r_phase;

  // Voice generators. Stopping the sequencer wins over a trigger in the same cycle.
  // NOTE: state is updated with <= only, so every voice reads the pre-edge values of the others.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_active <= '0;
      r_phase  <= '0;
      for (int i = 0; i < 5; i++) begin
        r_tone_cnt[i]  <= '0;
        r_burst_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!Playing) begin
          r_active[i]    <= 1'b0;
          r_phase[i]     <= 1'b0;
          r_tone_cnt[i]  <= '0;
          r_burst_cnt[i] <= '0;
        end else if (w_trig[i]) begin
          r_active[i]    <= 1'b1;
          r_phase[i]     <= 1'b1;
          r_tone_cnt[i]  <= HALF[i] - 16'd1;
          r_burst_cnt[i] <= BURST_LEN - 1'b1;
        end else if (r_active[i]) begin
          if (r_burst_cnt[i] == '0) begin
            r_active[i]    <= 1'b0;
            r_phase[i]     <= 1'b0;
            r_tone_cnt[i]  <= '0;
          end else begin
            r_burst_cnt[i] <= r_burst_cnt[i] - 1'b1;
            if (r_tone_cnt[i] == '0) begin
              r_tone_cnt[i] <= HALF[i] - 16'd1;
              r_phase[i]    <= ~r_phase[i];
            end else begin
              r_tone_cnt[i] <= r_tone_cnt[i] - 16'd1;
            end
          end
        end
      end
    end
  end

  // Mixer and PWM DAC; the slot counter free-runs so duty is AudioSum/5.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sum     <= '0;
      r_pwm_cnt <= '0;
      r_pwm     <= 1'b0;
    end else begin
      r_sum     <= 3'($countones(w_levels));
      r_pwm_cnt <= (r_pwm_cnt == 3'd4) ? 3'd0 : r_pwm_cnt + 3'd1;
      r_pwm     <= (r_pwm_cnt < r_sum);
    end
  end

`ifdef HIT_LED_EN
  localparam int              LED_W    = 23;
  localparam logic [LED_W-1:0] LED_HOLD = 23'd4194304;

  logic [LED_W-1:0] r_led_cnt [5];

  // LED stretch survives a stop; only a new trigger or Reset touches it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 5; i++) r_led_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_trig[i])                r_led_cnt[i] <= LED_HOLD;
        else if (r_led_cnt[i] != '0)  r_led_cnt[i] <= r_led_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    HitLed = '0;
    for (int i = 0; i < 5; i++) HitLed[i] = (r_led_cnt[i] != '0);
  end
`endif

  assign VoiceActive = r_active;
  assign AudioSum    = r_sum;
  assign AudioPwm    = r_pwm;
  assign Busy        = |r_active;

endmodule
